// File: rtl/serial_operand_port.sv
// ---------------------------------------------------------------------------
// serial_operand_port
//   Bit-serial operand/result port for the serialized ALU datapath.
//   Captures two WIDTH-bit operands on an accepted start, streams them
//   LSB-first to the ALU alongside the shared count/reg_write sequencing, and
//   collects the returned result stream into a parallel word.
//
//   clk        in   system clock, all state updates on posedge
//   reset      in   asynchronous active-low reset
//   start      in   operation request, only honoured in IDLE
//   rs1_val    in   operand 1, captured on accepted start
//   rs2_val    in   operand 2, captured on accepted start
//   rd_d       in   serial result bit from ALU (ALU drives it on negedge)
//   rs1_d      out  serial operand 1 bit, LSB-first
//   rs2_d      out  serial operand 2 bit, LSB-first
//   count      out  sequence counter shared with the ALU (0..WIDTH+2)
//   reg_write  out  operand bits valid (count 2..WIDTH+1)
//   busy       out  sequence in progress
//   done       out  one-cycle pulse, rd_val valid from here until next done
//   rd_val     out  deserialized result
//
//   state  | meaning
//   IDLE   | count=0, waiting for start
//   PRIME  | count=1, operand bit 0 presented, reg_write low
//   SHIFT  | count=2..WIDTH+1, operand bit (count-2) presented, result captured
//   FINISH | count=WIDTH+2, ALU clears carry; result published on exit
//
//   The 7-bit count port limits WIDTH to 125 or less.
// ---------------------------------------------------------------------------
module serial_operand_port #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic             rd_d,
    output logic             rs1_d,
    output logic             rs2_d,
    output logic [6:0]       count,
    output logic             reg_write,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_val
);

    localparam logic [6:0] CNT_LAST_SHIFT = 7'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [6:0]       count_nxt;
    logic             load_ops;
    logic [WIDTH-1:0] rs1_sr, rs2_sr, rd_sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = 7'd0;
        load_ops  = 1'b0;
        rs1_d     = 1'b0;
        rs2_d     = 1'b0;
        reg_write = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_ops  = 1'b1;
                    count_nxt = 7'd1;
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                busy      = 1'b1;
                rs1_d     = rs1_sr[0];
                rs2_d     = rs2_sr[0];
                count_nxt = count + 7'd1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                rs1_d     = rs1_sr[0];
                rs2_d     = rs2_sr[0];
                count_nxt = count + 7'd1;
                if (count == CNT_LAST_SHIFT) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                busy      = 1'b1;
                count_nxt = 7'd0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers hold still through PRIME so bit 0 is seen for both
    // count=1 and count=2; they advance only on edges taken inside SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 7'd0;
            rs1_sr <= '0;
            rs2_sr <= '0;
            rd_sr  <= '0;
            rd_val <= '0;
            done   <= 1'b0;
        end else begin
            count <= count_nxt;
            done  <= (state == FINISH);
            if (load_ops) begin
                rs1_sr <= rs1_val;
                rs2_sr <= rs2_val;
            end else if (state == SHIFT) begin
                rs1_sr <= rs1_sr >> 1;
                rs2_sr <= rs2_sr >> 1;
            end
            // Result arrives LSB-first; shifting in at the MSB leaves bit 0
            // at the bottom after WIDTH captures.
            if (state == SHIFT) begin
                rd_sr <= {rd_d, rd_sr[WIDTH-1:1]};
            end
            if (state == FINISH) begin
                rd_val <= rd_sr;
            end
        end
    end

endmodule

// File: tb/tb_serial_operand_port.sv
module tb_serial_operand_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] rs1_val = '0;
    logic [63:0] rs2_val = '0;
    logic        rd_d = 1'b0;
    logic        rs1_d, rs2_d, reg_write, busy, done;
    logic [6:0]  count;
    logic [63:0] rd_val;

    serial_operand_port #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_d(rd_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .count(count),
        .reg_write(reg_write), .busy(busy), .done(done), .rd_val(rd_val)
    );

    always #5 clk = ~clk;

    // Serial ALU model: result bit driven on negedge while operand bits are
    // valid; carry cleared outside the operand window. rd_d forced high
    // otherwise so stray captures corrupt the result.
    logic alu_xor = 1'b1;
    logic carry = 1'b0;
    always @(negedge clk) begin
        if (reg_write) begin
            if (alu_xor) begin
                rd_d = rs1_d ^ rs2_d;
            end else begin
                rd_d  = rs1_d ^ rs2_d ^ carry;
                carry = (rs1_d & rs2_d) | (carry & (rs1_d ^ rs2_d));
            end
        end else begin
            rd_d  = 1'b1;
            carry = 1'b0;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        xm;
        logic [63:0] exp;
    } vec_t;

    // Runs one operation from start to done. Operands are disturbed right
    // after acceptance; they must have no effect.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic xm,
                          output int lat, output int rw_cnt, output logic [63:0] s1,
                          output logic [63:0] s2, output int max_cnt, output int overlap);
        int idx;
        @(negedge clk);
        rs1_val = a; rs2_val = b; alu_xor = xm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rs1_val = ~a; rs2_val = ~b;
        lat = 1; rw_cnt = 0; s1 = '0; s2 = '0; max_cnt = 0; overlap = 0;
        while (!done && lat < 200) begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (busy && done) overlap++;
            if (reg_write) begin
                rw_cnt++;
                idx = int'(count) - 2;
                if (idx >= 0 && idx < 64) begin
                    s1[idx] = rs1_d;
                    s2[idx] = rs2_d;
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        if (busy && done) overlap++;
    endtask

    vec_t vtab[6];

    initial begin
        int lat, rw_cnt, max_cnt, overlap, n;
        logic [63:0] s1, s2, first_res;

        vtab[0] = '{64'hA5A5_0000_FFFF_0001, 64'h0, 1'b1, 64'hA5A5_0000_FFFF_0001};
        vtab[1] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 1'b1, 64'hFEDC_4567_7654_CDEF};
        vtab[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0};
        vtab[3] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000};
        vtab[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001};
        vtab[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {57'd0, count}, 64'd0);
        chk("rst_outs", {58'd0, rs1_d, rs2_d, reg_write, busy, done, 1'b0}, 64'd0);
        chk("rst_rd_val", rd_val, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            run_op(vtab[i].a, vtab[i].b, vtab[i].xm, lat, rw_cnt, s1, s2, max_cnt, overlap);
            chk($sformatf("v%0d_rd_val", i), rd_val, vtab[i].exp);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd67);
            chk($sformatf("v%0d_reg_write_cycles", i), 64'(rw_cnt), 64'd64);
            chk($sformatf("v%0d_rs1_stream", i), s1, vtab[i].a);
            chk($sformatf("v%0d_rs2_stream", i), s2, vtab[i].b);
            chk($sformatf("v%0d_max_count", i), 64'(max_cnt), 64'd66);
            chk($sformatf("v%0d_busy_done_overlap", i), 64'(overlap), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
            chk($sformatf("v%0d_rd_val_hold", i), rd_val, vtab[i].exp);
        end

        // Start pulsed mid-sequence with new operands: ignored
        @(negedge clk);
        rs1_val = 64'h0123_4567_89AB_CDEF; rs2_val = 64'hFFFF_0000_FFFF_0000; alu_xor = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (count != 7'd40 && n < 200) begin @(posedge clk); #1; n++; end
        start = 1'b1; rs1_val = 64'hDEAD_BEEF_DEAD_BEEF; rs2_val = 64'h0;
        @(posedge clk); #1;
        start = 1'b0; n++;
        chk("ignore_count", {57'd0, count}, 64'd41);
        while (!done && n < 200) begin @(posedge clk); #1; n++; end
        chk("ignore_latency", 64'(n), 64'd67);
        chk("ignore_rd_val", rd_val, 64'hFEDC_4567_7654_CDEF);
        @(posedge clk); #1;
        chk("ignore_no_restart", {63'd0, busy}, 64'd0);

        // Back-to-back with start held high; second op accepted in done cycle
        @(negedge clk);
        rs1_val = 64'h0123_4567_89AB_CDEF; rs2_val = 64'hFFFF_0000_FFFF_0000; alu_xor = 1'b1; start = 1'b1;
        n = 0;
        while (!done && n < 200) begin @(posedge clk); #1; n++; end
        first_res = rd_val;
        chk("b2b_first_res", first_res, 64'hFEDC_4567_7654_CDEF);
        chk("b2b_done_cycle_busy", {63'd0, busy}, 64'd0);
        rs1_val = 64'h5555_5555_5555_5555; rs2_val = 64'hFFFF_FFFF_0000_0000;
        @(posedge clk); #1;
        chk("b2b_reaccept_busy", {63'd0, busy}, 64'd1);
        chk("b2b_reaccept_count", {57'd0, count}, 64'd1);
        n = 1;
        while (!done && n < 200) begin @(posedge clk); #1; n++; end
        start = 1'b0;
        chk("b2b_second_latency", 64'(n), 64'd67);
        chk("b2b_second_res", rd_val, 64'hAAAA_AAAA_5555_5555);

        // Reset mid-SHIFT at count=30: bit 28 of operand is 1 so rs1_d is high
        @(posedge clk);
        @(negedge clk);
        rs1_val = 64'h0000_0000_1000_0000; rs2_val = 64'h0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (count != 7'd30 && n < 200) begin @(posedge clk); #1; n++; end
        chk("pre_reset_rs1_d", {63'd0, rs1_d}, 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_count", {57'd0, count}, 64'd0);
        chk("midrst_outs", {58'd0, rs1_d, rs2_d, reg_write, busy, done, 1'b0}, 64'd0);
        chk("midrst_rd_val", rd_val, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        chk("midrst_no_done_after_release", 64'(n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
